// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the bus widths, empty values and the fetch FSM state encoding.
package inst_fetch_responder_pkg;

    localparam int addrWidth = 32;
    localparam int instWidth = 32;

    localparam logic [addrWidth-1:0] emptyAddr = '0;
    localparam logic [instWidth-1:0] emptyInst = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MISS_REQ = 2'd1,
        ST_READ     = 2'd2,
        ST_HOLD     = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_responder_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, synchronous fill, valid bits cleared on reset.
module icache_dm
    import inst_fetch_responder_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int MEM_BITS = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MEM_BITS-3:0]    i_rd_word,
    output logic                   o_hit,
    output logic [instWidth-1:0]   o_rd_data,
    input  logic                   i_we,
    input  logic [MEM_BITS-3:0]    i_wr_word,
    input  logic [instWidth-1:0]   i_wr_data
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = MEM_BITS - 2 - IDX_W;

    logic [TAG_W-1:0]     r_tag  [ENTRIES];
    logic [instWidth-1:0] r_data [ENTRIES];
    logic [ENTRIES-1:0]   r_valid;

    logic [IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_wr_tag;

    assign w_rd_idx = i_rd_word[IDX_W-1:0];
    assign w_rd_tag = i_rd_word[MEM_BITS-3:IDX_W];
    assign w_wr_idx = i_wr_word[IDX_W-1:0];
    assign w_wr_tag = i_wr_word[MEM_BITS-3:IDX_W];

    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_data = r_data[w_rd_idx];

    // Valid bits: cleared on reset, set by a line fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[w_wr_idx] <= TRUE;
        end
    end

    // Tag and data arrays: written on a line fill, no reset needed.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: serves PC-unit fetches from a
// direct-mapped cache, filling misses byte-wise from the shared RAM.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int MEM_BITS = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   fetch_req,
    input  logic [addrWidth-1:0]   fetch_addr,
    output logic                   fetch_done,
    output logic [instWidth-1:0]   fetch_inst,
    input  logic                   flush,
    output logic                   mem_req,
    input  logic                   mem_grant,
    output logic [addrWidth-1:0]   mem_a,
    input  logic [7:0]             mem_din
);

    fetch_state_t         r_state;
    logic [addrWidth-1:0] r_addr;
    logic [1:0]           r_cnt;
    logic [23:0]          r_buf;
    logic                 r_done;
    logic [instWidth-1:0] r_inst;
    logic                 r_mem_req;
    logic [addrWidth-1:0] r_mem_a;

    logic [addrWidth-1:0] w_addr;
    logic                 w_hit;
    logic [instWidth-1:0] w_hit_data;
    logic                 w_we;
    logic [instWidth-1:0] w_fill;
    logic [1:0]           w_unused_lo;

    assign w_addr      = {fetch_addr[addrWidth-1:2], 2'b00};
    assign w_unused_lo = fetch_addr[1:0];
    assign w_fill      = {mem_din, r_buf};

    // Fill the line only when the last byte lands and nothing cancels it.
    assign w_we = rdy && !rst && !flush
               && (r_state == ST_READ) && (r_cnt == 2'd3);

    icache_dm #(
        .ENTRIES  (ENTRIES),
        .MEM_BITS (MEM_BITS)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .i_rd_word (fetch_addr[MEM_BITS-1:2]),
        .o_hit     (w_hit),
        .o_rd_data (w_hit_data),
        .i_we      (w_we),
        .i_wr_word (r_addr[MEM_BITS-1:2]),
        .i_wr_data (w_fill)
    );

    // Fetch FSM with byte counter, assembly buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= emptyAddr;
            r_cnt     <= 2'd0;
            r_buf     <= '0;
            r_done    <= FALSE;
            r_inst    <= emptyInst;
            r_mem_req <= FALSE;
            r_mem_a   <= emptyAddr;
        end else if (rdy) begin
            r_done <= FALSE;
            if (flush) begin
                r_state   <= ST_IDLE;
                r_mem_req <= FALSE;
                r_cnt     <= 2'd0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (fetch_req) begin
                            r_addr <= w_addr;
                            if (w_hit) begin
                                r_done  <= TRUE;
                                r_inst  <= w_hit_data;
                                r_state <= ST_HOLD;
                            end else begin
                                r_mem_req <= TRUE;
                                r_mem_a   <= w_addr;
                                r_state   <= ST_MISS_REQ;
                            end
                        end
                    end
                    ST_MISS_REQ: begin
                        if (mem_grant) begin
                            r_cnt   <= 2'd0;
                            r_mem_a <= r_addr + 32'd1;
                            r_state <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        r_cnt <= r_cnt + 2'd1;
                        unique case (r_cnt)
                            2'd0: begin
                                r_buf[7:0] <= mem_din;
                                r_mem_a    <= r_addr + 32'd2;
                            end
                            2'd1: begin
                                r_buf[15:8] <= mem_din;
                                r_mem_a     <= r_addr + 32'd3;
                            end
                            2'd2: begin
                                r_buf[23:16] <= mem_din;
                                r_mem_req    <= FALSE;
                            end
                            2'd3: begin
                                r_inst  <= w_fill;
                                r_done  <= TRUE;
                                r_state <= ST_HOLD;
                            end
                        endcase
                    end
                    ST_HOLD: begin
                        if (!fetch_req) begin
                            r_state <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign fetch_done = r_done;
    assign fetch_inst = r_inst;
    assign mem_req    = r_mem_req;
    assign mem_a      = r_mem_a;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder with a byte RAM and
// a grant model whose delay is programmable per test.
module tb_inst_fetch_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_done;
    logic [31:0] fetch_inst;
    logic        flush = 1'b0;
    logic        mem_req;
    logic        mem_grant;
    logic [31:0] mem_a;
    logic [7:0]  mem_din = '0;

    logic [7:0] ram [1024];
    int gdelay = 0;
    int r_wait = 0;
    int n_checks = 0;
    int n_fail = 0;
    int n_done;
    int n_req;

    inst_fetch_responder #(
        .ENTRIES  (64),
        .MEM_BITS (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_done (fetch_done),
        .fetch_inst (fetch_inst),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_grant  (mem_grant),
        .mem_a      (mem_a),
        .mem_din    (mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[9:0]];
    end

    always @(posedge clk) begin
        if (!mem_req) r_wait <= 0;
        else          r_wait <= r_wait + 1;
    end

    assign mem_grant = mem_req && (r_wait >= gdelay);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input int exp_lat,
                         input int exp_gap);
        int lat;
        int g;
        bit seen;
        bit a_bad;
        fetch_addr = addr;
        fetch_req  = 1'b1;
        lat = 0;
        g = -1;
        seen = 1'b0;
        a_bad = 1'b0;
        do begin
            tick();
            lat++;
            if (mem_req) seen = 1'b1;
            if (g < 0 && mem_req && mem_grant) g = lat;
            if (mem_req && g < 0 && mem_a !== addr) a_bad = 1'b1;
            if (g >= 0 && lat - g <= 3 && mem_a !== addr + 32'(lat - g))
                a_bad = 1'b1;
            if (g >= 0 && lat - g >= 4 && mem_req) a_bad = 1'b1;
        end while (!fetch_done && lat < 40);
        check({tag, " lat"}, 32'(lat), 32'(exp_lat));
        check({tag, " inst"}, fetch_inst, exp_inst);
        if (exp_gap < 0) begin
            check({tag, " memreq"}, 32'(seen), 32'd0);
        end else begin
            check({tag, " gap"}, 32'(lat - g), 32'(exp_gap));
            check({tag, " addr seq"}, 32'(a_bad), 32'd0);
        end
        fetch_req = 1'b0;
        tick();
        check({tag, " pulse"}, 32'(fetch_done), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " done"}, 32'(fetch_done), 32'd0);
        check({tag, " inst"}, fetch_inst, 32'd0);
        check({tag, " mreq"}, 32'(mem_req), 32'd0);
        check({tag, " mem_a"}, mem_a, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h010] = 8'h13; ram[10'h011] = 8'h05;
        ram[10'h012] = 8'h00; ram[10'h013] = 8'h00;
        ram[10'h020] = 8'h93; ram[10'h021] = 8'h00;
        ram[10'h022] = 8'h10; ram[10'h023] = 8'h00;
        ram[10'h030] = 8'hb7; ram[10'h031] = 8'h12;
        ram[10'h032] = 8'h34; ram[10'h033] = 8'h56;
        ram[10'h000] = 8'h11; ram[10'h001] = 8'h22;
        ram[10'h002] = 8'h33; ram[10'h003] = 8'h44;
        ram[10'h100] = 8'haa; ram[10'h101] = 8'hbb;
        ram[10'h102] = 8'hcc; ram[10'h103] = 8'hdd;
        ram[10'h040] = 8'h01; ram[10'h041] = 8'h02;
        ram[10'h042] = 8'h03; ram[10'h043] = 8'h04;

        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        fetch("cold", 32'h10, 32'h00000513, 6, 5);
        fetch("hit", 32'h10, 32'h00000513, 1, -1);

        gdelay = 5;
        fetch("slow", 32'h20, 32'h00100093, 11, 5);
        gdelay = 0;

        fetch_addr = 32'h30;
        fetch_req  = 1'b1;
        tick();
        tick();
        tick();
        check("flush byte2 addr", mem_a, 32'h32);
        flush = 1'b1;
        fetch_req = 1'b0;
        tick();
        flush = 1'b0;
        check("flush mreq", 32'(mem_req), 32'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (fetch_done) n_done++;
            tick();
        end
        check("flush no done", 32'(n_done), 32'd0);
        check("flush inst kept", fetch_inst, 32'h00100093);
        fetch("refetch", 32'h30, 32'h563412b7, 6, 5);

        fetch_addr = 32'h10;
        fetch_req  = 1'b1;
        tick();
        check("hold done", 32'(fetch_done), 32'd1);
        n_done = 0;
        n_req = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fetch_done) n_done++;
            if (mem_req) n_req++;
        end
        check("hold no redo", 32'(n_done), 32'd0);
        check("hold no mem", 32'(n_req), 32'd0);
        fetch_req = 1'b0;
        tick();
        fetch("rehit", 32'h10, 32'h00000513, 1, -1);

        fetch("conf0 a", 32'h000, 32'h44332211, 6, 5);
        fetch("conf100 a", 32'h100, 32'hddccbbaa, 6, 5);
        fetch("conf0 b", 32'h000, 32'h44332211, 6, 5);
        fetch("conf100 b", 32'h100, 32'hddccbbaa, 6, 5);

        fetch_addr = 32'h40;
        fetch_req  = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        fetch_req = 1'b0;
        tick();
        check_zero("midrst");
        rst = 1'b0;
        tick();
        fetch("post rst", 32'h40, 32'h04030201, 6, 5);
        fetch("post rst old", 32'h10, 32'h00000513, 6, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
